// File: rtl/ft_packet_deframer.sv
// ---------------------------------------------------------------------------
// ft_packet_deframer
//
// Purpose:
//   Reads 16-bit words from the first-word-fall-through read side of the FT
//   FIFO user interface and hunts for 8-word telemetry frames:
//     six payload words (the sixth carries marker 0x7C in its high byte),
//     followed by trailer words 0xF00D and 0xC0DE.
//   Each good frame is reassembled into an 88-bit packet
//   {w5[7:0], w4, w3, w2, w1, w0} and presented on a valid/ready output so
//   host-injected packets can be replayed into telemetry_check.
//
// Ports:
//   clk_128M       in   sole clock
//   rst_n          in   asynchronous active-low reset
//   ui_dout        in   FIFO read data (first-word-fall-through)
//   ui_dout_be     in   byte enables of ui_dout
//   ui_dout_empty  in   FIFO empty
//   ui_dout_get    out  pop request (drops only while the output is stalled)
//   data_out       out  reassembled 88-bit packet
//   valid_out      out  packet available
//   ready_in       in   downstream accepts packet
//   in_sync        out  frame lock indicator
//   frame_count    out  frames emitted (stats)
//   error_count    out  saturating framing error count (stats)
//
// Optional feature:
//   FT_DEFRAMER_STATS_EN - when defined, frame_count and error_count are real
//   counters; when undefined both outputs are tied to zero and no counter
//   flops exist. Framing, in_sync and the handshake do not depend on it.
// ---------------------------------------------------------------------------
module ft_packet_deframer #(
    parameter int ERR_W      = 16,
    parameter int LOSS_WORDS = 16
) (
    input  logic             clk_128M,
    input  logic             rst_n,
    input  logic [15:0]      ui_dout,
    input  logic [1:0]       ui_dout_be,
    input  logic             ui_dout_empty,
    output logic             ui_dout_get,
    output logic [87:0]      data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             in_sync,
    output logic [31:0]      frame_count,
    output logic [ERR_W-1:0] error_count
);

    localparam logic [15:0] TRAILER_HI = 16'hF00D;
    localparam logic [15:0] TRAILER_LO = 16'hC0DE;
    localparam logic [7:0]  MARKER     = 8'h7C;
    localparam logic [4:0]  FILL_MIN   = 5'd7;
    localparam logic [4:0]  FILL_MAX   = 5'd31;
    localparam logic [4:0]  LOSS_LIMIT = 5'(LOSS_WORDS);

    // win[6] is the most recent previously accepted word, win[0] the oldest.
    logic [15:0] win [7];
    logic [4:0]  fill;
    logic [4:0]  fill_inc;

    logic accept;
    logic trailer_seen;
    logic marker_ok;
    logic fill_ok;
    logic be_ok;
    logic match;
    logic frame_err;

    // Popping only pauses while a finished packet waits for the consumer, so
    // a new match can never overwrite an unaccepted packet.
    assign ui_dout_get = rst_n && !(valid_out && !ready_in);
    assign accept      = ui_dout_get && !ui_dout_empty;

    // Frame recognition on the incoming word against the window contents.
    always_comb begin
        trailer_seen = (ui_dout == TRAILER_LO) && (win[6] == TRAILER_HI);
        marker_ok    = (win[5][15:8] == MARKER);
        fill_ok      = (fill >= FILL_MIN);
        be_ok        = (ui_dout_be == 2'b11);
        match        = accept && trailer_seen && marker_ok && fill_ok && be_ok;
        // A partial word or a trailer without a full, well-marked payload is
        // one framing error, even when both causes coincide.
        frame_err    = accept && (!be_ok || (trailer_seen && !(marker_ok && fill_ok)));
        fill_inc     = (fill == FILL_MAX) ? FILL_MAX : fill + 5'd1;
    end

    // Seven-word history; every accepted word shifts in, including bad ones.
    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) begin
                win[i] <= 16'h0000;
            end
        end else if (accept) begin
            for (int i = 0; i < 6; i++) begin
                win[i] <= win[i+1];
            end
            win[6] <= ui_dout;
        end
    end

    // Fill counter and lock tracking. A long run of words without a match
    // drops lock silently; only genuine framing faults are counted.
    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            fill    <= 5'd0;
            in_sync <= 1'b0;
        end else if (accept) begin
            if (match) begin
                fill    <= 5'd0;
                in_sync <= 1'b1;
            end else if (frame_err) begin
                fill    <= 5'd0;
                in_sync <= 1'b0;
            end else begin
                fill <= fill_inc;
                if (fill_inc >= LOSS_LIMIT) begin
                    in_sync <= 1'b0;
                end
            end
        end
    end

    // Output register. A match landing on the same edge as a completed
    // handshake replaces the old packet and keeps valid_out high.
    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= 88'd0;
            valid_out <= 1'b0;
        end else if (match) begin
            data_out  <= {win[5][7:0], win[4], win[3], win[2], win[1], win[0]};
            valid_out <= 1'b1;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

`ifdef FT_DEFRAMER_STATS_EN
    logic [31:0]      frame_cnt_q;
    logic [ERR_W-1:0] err_cnt_q;

    // Statistics: frame count wraps, error count sticks at all-ones.
    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= '0;
        end else begin
            if (match) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (frame_err && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign error_count = err_cnt_q;
`else
    assign frame_count = 32'd0;
    assign error_count = '0;
`endif

endmodule
